// File: rtl/result_stream_port_pkg.sv
// Shared types and derived-constant helpers for the result stream port.
package result_stream_port_pkg;

  // Serializer state: IDLE while the FIFO is empty, SEND while a head word is being emitted.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of chunks making up one captured word.
  function automatic int unsigned f_nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index; at least one bit so a single-chunk word still has an index.
  function automatic int unsigned f_idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/result_stream_port_word_fifo.sv
// Word FIFO: storage, wrapping pointers and occupancy count.
// Caller qualifies i_push/i_pop so that only accepted operations reach this block.
module word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/result_stream_port.sv
// Captures CPU result words into a FIFO and streams them out LSB-chunk first
// over a valid/ack handshake, with a sticky overflow flag for dropped captures.
module result_stream_port
  import result_stream_port_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_in_valid,
  input  logic                     mode,
  input  logic                     chunk_ack,
  input  logic                     clear_ovf,
  output logic [CHUNK-1:0]         chunk_out,
  output logic                     chunk_valid,
  output logic                     chunk_last,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned NCHUNK = f_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = f_idx_w(NCHUNK);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [IDXW-1:0]              r_idx;
  logic                         r_ovf;
  logic [WIDTH-1:0]             r_last_word;
  logic                         r_have_word;

  logic [WIDTH-1:0]             w_head;
  logic [NCHUNK-1:0][CHUNK-1:0] w_chunks;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_capture;
  logic                         w_xfer;
  logic                         w_is_last;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_drop;

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (data_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Capture decision, handshake and push/pop qualification.
  always_comb begin
    w_capture = data_in_valid && (mode || !r_have_word || (data_in != r_last_word));
    w_xfer    = !w_empty && chunk_ack;
    w_is_last = (r_idx == IDXW'(NCHUNK - 1));
    w_pop     = w_xfer && w_is_last;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push    = w_capture && (!w_full || w_pop);
    w_drop    = w_capture && w_full && !w_pop;
  end

  // Serializer next-state: leave SEND only when the final pop empties the FIFO.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_push) w_state_nxt = SEND;
      SEND:    if (w_pop && !w_push && (level == 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Serializer state and chunk index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) r_idx <= w_is_last ? '0 : r_idx + 1'b1;
    end
  end

  // Last-captured word tracking for on-change mode, and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_word <= '0;
      r_have_word <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_push) begin
        r_last_word <= data_in;
        r_have_word <= 1'b1;
      end
      if (w_drop)         r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
    end
  end

  // Outputs come from registered state only; zeroed while nothing is queued.
  always_comb begin
    w_chunks    = w_head;
    chunk_valid = !w_empty;
    chunk_out   = chunk_valid ? w_chunks[r_idx] : '0;
    chunk_last  = chunk_valid && w_is_last;
    ovf         = r_ovf;
  end

endmodule

// File: tb/tb_result_stream_port.sv
// Scoreboard bench for result_stream_port: a 32/8/4 instance driven cycle by cycle
// against a reference queue, plus a 64/16 instance for wide-chunk ordering.
module tb_result_stream_port;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        chunk_ack = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [7:0]  chunk_out;
  logic        chunk_valid;
  logic        chunk_last;
  logic        ovf;
  logic [2:0]  level;

  logic [63:0] d64_in = '0;
  logic        d64_valid = 1'b0;
  logic        d64_ack = 1'b0;
  logic [15:0] d64_chunk;
  logic        d64_cvalid;
  logic        d64_clast;
  logic        d64_ovf;
  logic [2:0]  d64_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] q[$];
  int unsigned m_idx;
  logic [31:0] m_lastw;
  logic        m_have;
  logic        m_ovf;

  always #5 clk = ~clk;

  result_stream_port #(.WIDTH(32), .CHUNK(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .mode(mode), .chunk_ack(chunk_ack), .clear_ovf(clear_ovf),
    .chunk_out(chunk_out), .chunk_valid(chunk_valid), .chunk_last(chunk_last),
    .ovf(ovf), .level(level)
  );

  result_stream_port #(.WIDTH(64), .CHUNK(16), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .data_in(d64_in), .data_in_valid(d64_valid),
    .mode(1'b1), .chunk_ack(d64_ack), .clear_ovf(1'b0),
    .chunk_out(d64_chunk), .chunk_valid(d64_cvalid), .chunk_last(d64_clast),
    .ovf(d64_ovf), .level(d64_level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx   = 0;
    m_lastw = '0;
    m_have  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock cycle: check outputs against the reference, drive, advance both.
  task automatic cyc(input logic v, input logic [31:0] d, input logic md,
                     input logic ack, input logic clr);
    logic [31:0] hw;
    logic cap, full, xfer, pop, push, drop;
    check("valid", chunk_valid, q.size() != 0);
    check("level", level, q.size());
    check("ovf", ovf, m_ovf);
    if (q.size() != 0) begin
      hw = q[0];
      check("chunk", chunk_out, hw[m_idx*8 +: 8]);
      check("last", chunk_last, m_idx == 3);
    end
    data_in = d; data_in_valid = v; mode = md; chunk_ack = ack; clear_ovf = clr;
    cap  = v && (md || !m_have || d != m_lastw);
    full = q.size() == DEPTH;
    xfer = (q.size() != 0) && ack;
    pop  = xfer && (m_idx == 3);
    push = cap && (!full || pop);
    drop = cap && full && !pop;
    @(posedge clk);
    if (xfer) begin
      if (pop) begin
        void'(q.pop_front());
        m_idx = 0;
      end else m_idx++;
    end
    if (push) begin
      q.push_back(d);
      m_lastw = d;
      m_have  = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk);
    data_in_valid = 1'b0; chunk_ack = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", chunk_valid, 1'b0);
    check("rst_last", chunk_last, 1'b0);
    check("rst_chunk", chunk_out, 8'h00);
    check("rst_level", level, 3'd0);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  logic [7:0]  exp36 [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [15:0] exp41 [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single word streamed with ack held high
    cyc(1'b1, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("s36_chunk", chunk_out, exp36[k]);
      check("s36_last", chunk_last, k == 3);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    check("s36_idle", chunk_valid, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // On-change mode: first word after reset captured even if zero, repeats suppressed
    do_reset();
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    check("s37_zero", level, 3'd1);
    drain(5);
    do_reset();
    cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
    check("s37_level", level, 3'd2);
    // Switching to every-valid captures the repeated value
    cyc(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    check("s29_level", level, 3'd3);
    drain(13);

    // Overflow, clear racing a drop, then clear alone
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h10 + i, 1'b1, 1'b0, 1'b0);
    check("s38_level", level, 3'd4);
    check("s38_ovf", ovf, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("s38_clr", ovf, 1'b0);
    cyc(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    check("s28_drop_wins", ovf, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drain(17);

    // Full FIFO, push coinciding with final-chunk pop
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC0DE0000 + i, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s39_last", chunk_last, 1'b1);
    cyc(1'b1, 32'h99887766, 1'b1, 1'b1, 1'b0);
    check("s39_level", level, 3'd4);
    check("s39_ovf", ovf, 1'b0);
    drain(12);
    check("s39_tail", chunk_out, 8'h66);
    drain(5);

    // Reset mid-word discards the partial transfer
    do_reset();
    cyc(1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    do_reset();
    cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    check("s40_chunk0", chunk_out, 8'hEF);
    drain(5);

    // Wide word, 16-bit chunks
    d64_in = 64'h0123456789ABCDEF; d64_valid = 1'b1; d64_ack = 1'b1;
    @(negedge clk);
    d64_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("s41_valid", d64_cvalid, 1'b1);
      check("s41_chunk", d64_chunk, exp41[k]);
      check("s41_last", d64_clast, k == 3);
      @(negedge clk);
    end
    check("s41_idle", d64_cvalid, 1'b0);
    check("s41_level", d64_level, 3'd0);
    check("s41_ovf", d64_ovf, 1'b0);
    d64_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
